// File: rtl/alu_sequencer_if.sv
// Entry, ALU and result signals of the ALU operand sequencer.
// The master side feeds words, the ALU result and the acknowledge; the slave side is the sequencer.
interface alu_sequencer_if;
  logic [5:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] x;
  logic [5:0] y;
  logic [3:0] fxn;
  logic [5:0] alu_answer;
  logic       alu_carry;
  logic       alu_o_flow;
  logic [5:0] result;
  logic       carry_out;
  logic       o_flow_out;
  logic       res_valid;
  logic       res_ack;
  logic [7:0] op_count;

  modport master (
    output data_in, in_valid, alu_answer, alu_carry, alu_o_flow, res_ack,
    input  in_ready, x, y, fxn, result, carry_out, o_flow_out, res_valid, op_count
  );

  modport slave (
    input  data_in, in_valid, alu_answer, alu_carry, alu_o_flow, res_ack,
    output in_ready, x, y, fxn, result, carry_out, o_flow_out, res_valid, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Collects operand A, operand B and a function word, lets the ALU settle for
// EXEC_CYCLES cycles, captures its result and holds it until acknowledged.
module alu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT_X = 3'd1,
    GOT_Y = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_r;
  logic [3:0] settle_r;
  logic       in_ready_r;
  logic [5:0] x_r;
  logic [5:0] y_r;
  logic [3:0] fxn_r;
  logic [5:0] result_r;
  logic       carry_r;
  logic       o_flow_r;
  logic       res_valid_r;
  logic [7:0] op_count_r;
  logic       accept_s;

  // in_ready_r is only ever high in the three entry states
  assign accept_s = bus.in_valid & in_ready_r;

  // Sequencer state machine with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      settle_r    <= 4'd0;
      in_ready_r  <= 1'b1;
      x_r         <= 6'd0;
      y_r         <= 6'd0;
      fxn_r       <= 4'd0;
      result_r    <= 6'd0;
      carry_r     <= 1'b0;
      o_flow_r    <= 1'b0;
      res_valid_r <= 1'b0;
      op_count_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r     <= bus.data_in;
            state_r <= GOT_X;
          end
        end
        GOT_X: begin
          if (accept_s) begin
            y_r     <= bus.data_in;
            state_r <= GOT_Y;
          end
        end
        GOT_Y: begin
          if (accept_s) begin
            fxn_r      <= {1'b0, bus.data_in[2:0]};
            settle_r   <= SETTLE_LOAD;
            in_ready_r <= 1'b0;
            state_r    <= EXEC;
          end
        end
        EXEC: begin
          if (settle_r == 4'd0) begin
            result_r <= bus.alu_answer;
            carry_r  <= bus.alu_carry;
            o_flow_r <= bus.alu_o_flow;
            state_r  <= DONE;
          end else begin
            settle_r <= settle_r - 4'd1;
          end
        end
        DONE: begin
          // res_valid rises one cycle into DONE; only a seen result can be acknowledged
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
          end else if (bus.res_ack) begin
            op_count_r  <= op_count_r + 8'd1;
            res_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          settle_r    <= 4'd0;
          in_ready_r  <= 1'b1;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.fxn        = fxn_r;
  assign bus.result     = result_r;
  assign bus.carry_out  = carry_r;
  assign bus.o_flow_out = o_flow_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.op_count   = op_count_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural team ALU,
// covering EXEC_CYCLES=1 and EXEC_CYCLES=4 instances.
module tb_alu_sequencer;

  typedef struct packed {
    logic       o;
    logic       c;
    logic [5:0] r;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] exp_ops;
  exp_t sb[$];

  alu_sequencer_if bus1 ();
  alu_sequencer_if bus4 ();

  alu_sequencer #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  alu_sequencer #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // Team ALU: {o_flow, carry, answer}; 6 = add, 7 = subtract
  function automatic logic [7:0] alu_model(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    logic [6:0] s;
    logic       o;
    s = 7'd0;
    o = 1'b0;
    case (f)
      3'd0: s = {1'b0, a & b};
      3'd1: s = {1'b0, a | b};
      3'd2: s = {1'b0, a ^ b};
      3'd3: s = {1'b0, ~a};
      3'd4: s = {1'b0, a};
      3'd5: s = {1'b0, b};
      3'd6: begin
        s = {1'b0, a} + {1'b0, b};
        o = (a[5] == b[5]) && (s[5] != a[5]);
      end
      3'd7: begin
        s = {1'b0, a} + {1'b0, ~b} + 7'd1;
        o = (a[5] != b[5]) && (s[5] != a[5]);
      end
      default: s = 7'd0;
    endcase
    return {o, s[6], s[5:0]};
  endfunction

  always_comb begin
    {bus1.alu_o_flow, bus1.alu_carry, bus1.alu_answer} = alu_model(bus1.x, bus1.y, bus1.fxn[2:0]);
    {bus4.alu_o_flow, bus4.alu_carry, bus4.alu_answer} = alu_model(bus4.x, bus4.y, bus4.fxn[2:0]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [5:0] w);
    check("in_ready_before_accept", {31'd0, bus1.in_ready}, 32'd1);
    bus1.data_in  = w;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [5:0] a, input logic [5:0] b, input logic [5:0] f);
    sb.push_back(exp_t'(alu_model(a, b, f[2:0])));
  endtask

  task automatic wait_result(input int lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus1.res_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_sb_has_entry"}, {31'd0, (sb.size() > 0)}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, {26'd0, bus1.result}, {26'd0, e.r});
      check({tag, "_carry"}, {31'd0, bus1.carry_out}, {31'd0, e.c});
      check({tag, "_oflow"}, {31'd0, bus1.o_flow_out}, {31'd0, e.o});
    end
  endtask

  task automatic ack_result(input string tag);
    bus1.res_ack = 1'b1;
    @(posedge clk);
    #1;
    bus1.res_ack = 1'b0;
    exp_ops = exp_ops + 8'd1;
    check({tag, "_op_count"}, {24'd0, bus1.op_count}, {24'd0, exp_ops});
    check({tag, "_back_to_idle"}, {30'd0, bus1.in_ready, bus1.res_valid}, 32'd2);
  endtask

  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] f, input string tag);
    send_word(a);
    send_word(b);
    send_word(f);
    push_exp(a, b, f);
    wait_result(2, tag);
    ack_result(tag);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check("reset_x", {26'd0, bus1.x}, 32'd0);
    check("reset_y", {26'd0, bus1.y}, 32'd0);
    check("reset_ready", {31'd0, bus1.in_ready}, 32'd1);
    check("reset_op_count", {24'd0, bus1.op_count}, 32'd0);
    #3;
    reset = 1'b0;
    exp_ops = 8'd0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] f;
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    failures = 0;
    exp_ops = 8'd0;
    bus1.data_in = 6'd0; bus1.in_valid = 1'b0; bus1.res_ack = 1'b0;
    bus4.data_in = 6'd0; bus4.in_valid = 1'b0; bus4.res_ack = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    check("rst_res_valid", {31'd0, bus1.res_valid}, 32'd0);
    check("rst_result", {26'd0, bus1.result}, 32'd0);
    check("rst_fxn", {28'd0, bus1.fxn}, 32'd0);
    #9;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);

    // Add
    send_word(6'b000101);
    send_word(6'b000011);
    send_word(6'b000110);
    push_exp(6'b000101, 6'b000011, 6'b000110);
    wait_result(2, "add");
    check("add_literal", {24'd0, bus1.o_flow_out, bus1.carry_out, bus1.result}, {24'd0, 2'b00, 6'b001000});
    ack_result("add");
    check("add_x_kept", {26'd0, bus1.x}, 32'd5);
    check("add_fxn_kept", {28'd0, bus1.fxn}, 32'd6);

    // Overflow
    run_op(6'b011110, 6'b000011, 6'b000110, "ovf");
    check("ovf_literal", {24'd0, bus1.o_flow_out, bus1.carry_out, bus1.result}, {24'd0, 2'b10, 6'b100001});

    // res_ack outside DONE is ignored
    bus1.res_ack = 1'b1;
    @(posedge clk);
    #1;
    bus1.res_ack = 1'b0;
    check("stray_ack_op_count", {24'd0, bus1.op_count}, {24'd0, exp_ops});

    // Subtract, high function bits ignored, entry blocked during EXEC/DONE
    send_word(6'b000011);
    send_word(6'b000101);
    send_word(6'b111111);
    push_exp(6'b000011, 6'b000101, 6'b111111);
    check("sub_fxn", {28'd0, bus1.fxn}, 32'd7);
    bus1.data_in  = 6'b101010;
    bus1.in_valid = 1'b1;
    check("sub_exec_not_ready", {31'd0, bus1.in_ready}, 32'd0);
    wait_result(2, "sub");
    check("sub_literal", {26'd0, bus1.result}, {26'd0, 6'b111110});
    check("sub_done_not_ready", {31'd0, bus1.in_ready}, 32'd0);
    check("sub_xy_kept", {20'd0, bus1.x, bus1.y}, {20'd0, 6'd3, 6'd5});
    bus1.in_valid = 1'b0;
    ack_result("sub");

    // Reset after two accepted words
    send_word(6'd9);
    send_word(6'd10);
    pulse_reset();
    run_op(6'b000001, 6'b000010, 6'b000110, "post_reset");
    check("post_reset_literal", {26'd0, bus1.result}, 32'd3);

    // res_ack held with in_valid in DONE
    send_word(6'd4);
    send_word(6'd4);
    send_word(6'd6);
    push_exp(6'd4, 6'd4, 6'd6);
    wait_result(2, "ackvalid");
    bus1.res_ack  = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.data_in  = 6'd17;
    @(posedge clk);
    #1;
    bus1.res_ack  = 1'b0;
    bus1.in_valid = 1'b0;
    exp_ops = exp_ops + 8'd1;
    check("ackvalid_op_count", {24'd0, bus1.op_count}, {24'd0, exp_ops});
    check("ackvalid_idle", {31'd0, bus1.in_ready}, 32'd1);
    check("ackvalid_x_kept", {26'd0, bus1.x}, 32'd4);
    @(posedge clk);
    #1;
    check("ackvalid_single_inc", {24'd0, bus1.op_count}, {24'd0, exp_ops});

    // 256 operations wrap op_count
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      a = 6'($urandom_range(0, 63));
      b = 6'($urandom_range(0, 63));
      f = 6'($urandom_range(0, 63));
      run_op(a, b, f, "wrap");
      if (i == 254) check("op_count_255", {24'd0, bus1.op_count}, 32'd255);
    end
    check("op_count_wrapped", {24'd0, bus1.op_count}, 32'd0);

    // EXEC_CYCLES = 4 latency
    check("ec4_ready", {31'd0, bus4.in_ready}, 32'd1);
    bus4.data_in = 6'd7;  bus4.in_valid = 1'b1; @(posedge clk); #1;
    bus4.data_in = 6'd9;  @(posedge clk); #1;
    bus4.data_in = 6'd6;  @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.res_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ec4_latency", n, 32'd5);
    check("ec4_result", {26'd0, bus4.result}, 32'd16);
    bus4.res_ack = 1'b1;
    @(posedge clk);
    #1;
    bus4.res_ack = 1'b0;
    check("ec4_op_count", {24'd0, bus4.op_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
